bp_mmio_mailbox_responder: RTL

- BedRock uncached I/O responder: the target end of a processor io_cmd/io_resp stream.
- Implements a 64-bit loopback mailbox: writes to TX_DATA push a FIFO, reads of RX_DATA pop it, plus STATUS and CLEAR registers.
- Sits behind the unicore I/O command demux beside other local devices, and serves host/NBF bring-up and I/O-path checkout.
- Exactly one command is outstanding at a time.

---
 rtl/bp_mmio_mailbox_responder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bp_mmio_mailbox_responder.sv
// BedRock uncached I/O responder exposing a 64-bit loopback mailbox.
// TX_DATA pushes a FIFO, RX_DATA pops it; STATUS and CLEAR manage stickies.
module bp_mmio_mailbox_responder #(
    parameter int els_p          = 8,
    parameter int lce_id_width_p = 2,
    parameter int addr_width_p   = 40
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic [3:0]                io_cmd_msg_type_i,
    input  logic [addr_width_p-1:0]   io_cmd_addr_i,
    input  logic [2:0]                io_cmd_size_i,
    input  logic [lce_id_width_p-1:0] io_cmd_lce_id_i,
    input  logic [63:0]               io_cmd_data_i,
    input  logic                      io_cmd_v_i,
    output logic                      io_cmd_ready_and_o,
    output logic [3:0]                io_resp_msg_type_o,
    output logic [addr_width_p-1:0]   io_resp_addr_o,
    output logic [2:0]                io_resp_size_o,
    output logic [lce_id_width_p-1:0] io_resp_lce_id_o,
    output logic [63:0]               io_resp_data_o,
    output logic                      io_resp_v_o,
    input  logic                      io_resp_yumi_i
);

    localparam int ptr_w = $clog2(els_p);
    localparam int cnt_w = ptr_w + 1;

    localparam logic [0:0] state_ready = 1'b0;
    localparam logic [0:0] state_resp  = 1'b1;

    logic [0:0]       state;
    logic [ptr_w-1:0] head;
    logic [ptr_w-1:0] tail;
    logic [cnt_w-1:0] count;
    logic             ovf;
    logic             unf;
    logic [63:0]      mem [els_p];

    logic [11:0] offset;
    logic [63:0] mask;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [63:0] status;
    logic        accept;
    logic        is_rd;
    logic        is_wr;
    logic        sel_tx;
    logic        sel_rx;
    logic        sel_st;
    logic        sel_clr;
    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic        ovf_set;
    logic        unf_set;
    logic        clr;

    assign offset  = io_cmd_addr_i[11:0];
    assign accept  = (state == state_ready) && io_cmd_v_i;
    assign is_rd   = (io_cmd_msg_type_i == 4'd2);
    assign is_wr   = (io_cmd_msg_type_i == 4'd3);
    assign sel_tx  = (offset == 12'h000);
    assign sel_rx  = (offset == 12'h008);
    assign sel_st  = (offset == 12'h010);
    assign sel_clr = (offset == 12'h018);
    assign empty   = (count == '0);
    assign full    = (count == cnt_w'(els_p));

    // Sizes above 3 behave as a full doubleword.
    always_comb begin
        mask = '1;
        if (!io_cmd_size_i[2]) begin
            unique case (io_cmd_size_i[1:0])
                2'd0:    mask = 64'h0000_0000_0000_00ff;
                2'd1:    mask = 64'h0000_0000_0000_ffff;
                2'd2:    mask = 64'h0000_0000_ffff_ffff;
                default: mask = '1;
            endcase
        end
    end

    assign wdata = io_cmd_data_i & mask;

    // Other opcodes read like uc_rd but never pop or set stickies.
    assign push    = accept && is_wr && sel_tx && !full;
    assign ovf_set = accept && is_wr && sel_tx && full;
    assign pop     = accept && is_rd && sel_rx && !empty;
    assign unf_set = accept && is_rd && sel_rx && empty;
    assign clr     = accept && is_wr && sel_clr && wdata[0];

    assign status = {48'b0, 8'(count), 4'b0, unf, ovf, full, empty};

    always_comb begin
        rdata = '0;
        if (!is_wr) begin
            unique case (1'b1)
                sel_rx:  rdata = empty ? 64'b0 : mem[head];
                sel_st:  rdata = status;
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[tail] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= state_ready;
            head  <= '0;
            tail  <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            if (accept) begin
                state <= state_resp;
            end else if ((state == state_resp) && io_resp_yumi_i) begin
                state <= state_ready;
            end
            if (push) begin
                tail  <= tail + 1'b1;
                count <= count + 1'b1;
            end
            if (pop) begin
                head  <= head + 1'b1;
                count <= count - 1'b1;
            end
            if (clr) begin
                ovf <= 1'b0;
                unf <= 1'b0;
            end else begin
                if (ovf_set) ovf <= 1'b1;
                if (unf_set) unf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            io_resp_msg_type_o <= '0;
            io_resp_addr_o     <= '0;
            io_resp_size_o     <= '0;
            io_resp_lce_id_o   <= '0;
            io_resp_data_o     <= '0;
        end else if (accept) begin
            io_resp_msg_type_o <= io_cmd_msg_type_i;
            io_resp_addr_o     <= io_cmd_addr_i;
            io_resp_size_o     <= io_cmd_size_i;
            io_resp_lce_id_o   <= io_cmd_lce_id_i;
            io_resp_data_o     <= rdata & mask;
        end
    end

    assign io_cmd_ready_and_o = (state == state_ready);
    assign io_resp_v_o        = (state == state_resp);

endmodule
